// File: rtl/cci_host_mem_responder.sv
// Host memory stand-in for CCI-MPF read/write channels: delayed in-order read
// responses from an on-chip cacheline memory and next-cycle write responses.
module cci_host_mem_responder #(
  parameter int ADDR_WIDTH     = 42,
  parameter int DATA_WIDTH     = 512,
  parameter int MDATA_WIDTH    = 16,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int RD_LATENCY     = 8,
  parameter int RSP_DEPTH      = 64,
  parameter int ALM_FULL_SLACK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_req_valid,
  input  logic [ADDR_WIDTH-1:0]  rd_req_addr,
  input  logic [MDATA_WIDTH-1:0] rd_req_mdata,
  output logic                   rd_alm_full,
  input  logic                   rd_rsp_stall,
  output logic                   rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]  rd_rsp_data,
  output logic [MDATA_WIDTH-1:0] rd_rsp_mdata,
  input  logic                   wr_req_valid,
  input  logic [ADDR_WIDTH-1:0]  wr_req_addr,
  input  logic [DATA_WIDTH-1:0]  wr_req_data,
  input  logic [MDATA_WIDTH-1:0] wr_req_mdata,
  output logic                   wr_alm_full,
  output logic                   wr_rsp_valid,
  output logic [MDATA_WIDTH-1:0] wr_rsp_mdata,
  output logic                   overflow,
  output logic                   idle
);

  localparam int QW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int MEM_LINES = 2 ** MEM_ADDR_WIDTH;
  localparam logic [QW:0] Q_FULL = (QW + 1)'(RSP_DEPTH);
  localparam logic [15:0] ALM_THRESH = 16'(RSP_DEPTH - ALM_FULL_SLACK);

  logic [DATA_WIDTH-1:0]     mem_r [MEM_LINES];
  logic [RD_LATENCY-1:0]     dl_valid_r;
  logic [MEM_ADDR_WIDTH-1:0] dl_idx_r [RD_LATENCY];
  logic [MDATA_WIDTH-1:0]    dl_mdata_r [RD_LATENCY];
  logic [MEM_ADDR_WIDTH-1:0] q_idx_r [RSP_DEPTH];
  logic [MDATA_WIDTH-1:0]    q_mdata_r [RSP_DEPTH];
  logic [QW-1:0]             q_wp_r;
  logic [QW-1:0]             q_rp_r;
  logic [QW:0]               q_count_r;
  logic                      overflow_r;
  logic                      rd_rsp_valid_r;
  logic [DATA_WIDTH-1:0]     rd_rsp_data_r;
  logic [MDATA_WIDTH-1:0]    rd_rsp_mdata_r;
  logic                      wr_rsp_valid_r;
  logic [MDATA_WIDTH-1:0]    wr_rsp_mdata_r;

  logic                      exit_valid_s;
  logic                      q_full_s;
  logic                      pop_s;
  logic                      push_s;
  logic                      drop_s;
  logic [15:0]               inflight_s;
  logic                      unused_s;

  // Upper address bits alias away by design.
  assign unused_s = &{1'b0, rd_req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                      wr_req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

  assign exit_valid_s = dl_valid_r[RD_LATENCY-1];
  assign q_full_s     = (q_count_r == Q_FULL);
  assign pop_s        = (q_count_r != '0) && !rd_rsp_stall;
  // A same-cycle pop frees a slot, so push at full with pop never drops.
  assign push_s       = exit_valid_s && (!q_full_s || pop_s);
  assign drop_s       = exit_valid_s && q_full_s && !pop_s;

  // Read-delay-line valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_r <= '0;
    end else begin
      dl_valid_r[0] <= rd_req_valid;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dl_valid_r[i] <= dl_valid_r[i-1];
      end
    end
  end

  // Unreset storage: memory lines, delay-line payload and queue payload.
  always_ff @(posedge clk) begin
    if (wr_req_valid) begin
      mem_r[wr_req_addr[MEM_ADDR_WIDTH-1:0]] <= wr_req_data;
    end
    dl_idx_r[0]   <= rd_req_addr[MEM_ADDR_WIDTH-1:0];
    dl_mdata_r[0] <= rd_req_mdata;
    for (int i = 1; i < RD_LATENCY; i++) begin
      dl_idx_r[i]   <= dl_idx_r[i-1];
      dl_mdata_r[i] <= dl_mdata_r[i-1];
    end
    if (push_s) begin
      q_idx_r[q_wp_r]   <= dl_idx_r[RD_LATENCY-1];
      q_mdata_r[q_wp_r] <= dl_mdata_r[RD_LATENCY-1];
    end
  end

  // Response queue pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wp_r     <= '0;
      q_rp_r     <= '0;
      q_count_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        q_wp_r <= q_wp_r + QW'(1);
      end
      if (pop_s) begin
        q_rp_r <= q_rp_r + QW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   q_count_r <= q_count_r + (QW + 1)'(1);
        2'b01:   q_count_r <= q_count_r - (QW + 1)'(1);
        default: q_count_r <= q_count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Registered read response; memory read is read-first against same-cycle writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_rsp_valid_r <= 1'b0;
      rd_rsp_data_r  <= '0;
      rd_rsp_mdata_r <= '0;
    end else begin
      rd_rsp_valid_r <= pop_s;
      if (pop_s) begin
        rd_rsp_data_r  <= mem_r[q_idx_r[q_rp_r]];
        rd_rsp_mdata_r <= q_mdata_r[q_rp_r];
      end
    end
  end

  // Write response one cycle after each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_rsp_valid_r <= 1'b0;
      wr_rsp_mdata_r <= '0;
    end else begin
      wr_rsp_valid_r <= wr_req_valid;
      if (wr_req_valid) begin
        wr_rsp_mdata_r <= wr_req_mdata;
      end
    end
  end

  // Reads in flight: occupied delay-line stages plus queued entries.
  always_comb begin
    inflight_s = 16'(q_count_r);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + 16'(dl_valid_r[i]);
    end
  end

  assign rd_alm_full  = (inflight_s >= ALM_THRESH);
  assign idle         = (inflight_s == 16'd0) && !wr_rsp_valid_r && !rd_rsp_valid_r;
  assign rd_rsp_valid = rd_rsp_valid_r;
  assign rd_rsp_data  = rd_rsp_data_r;
  assign rd_rsp_mdata = rd_rsp_mdata_r;
  assign wr_alm_full  = 1'b0;
  assign wr_rsp_valid = wr_rsp_valid_r;
  assign wr_rsp_mdata = wr_rsp_mdata_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_cci_host_mem_responder.sv
// Directed self-checking bench for cci_host_mem_responder with default parameters.
module tb_cci_host_mem_responder;

  localparam int AW = 42;
  localparam int DW = 512;
  localparam int MW = 16;
  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic [MW-1:0] rd_req_mdata;
  logic          rd_alm_full;
  logic          rd_rsp_stall;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic [MW-1:0] rd_rsp_mdata;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [MW-1:0] wr_req_mdata;
  logic          wr_alm_full;
  logic          wr_rsp_valid;
  logic [MW-1:0] wr_rsp_mdata;
  logic          overflow;
  logic          idle;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [DW-1:0] data_q[$];
  logic [MW-1:0] mdata_q[$];
  int            cyc_q[$];

  cci_host_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_alm_full(rd_alm_full), .rd_rsp_stall(rd_rsp_stall),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_mdata(rd_rsp_mdata),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_mdata(wr_req_mdata), .wr_alm_full(wr_alm_full),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_mdata(wr_rsp_mdata),
    .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every read response with the cycle it became visible.
  always @(negedge clk) begin
    if (rd_rsp_valid === 1'b1) begin
      data_q.push_back(rd_rsp_data);
      mdata_q.push_back(rd_rsp_mdata);
      cyc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rsp();
    data_q.delete();
    mdata_q.delete();
    cyc_q.delete();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int k = 0; k < budget && data_q.size() < n; k++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_mdata = '0;
    rd_rsp_stall = 1'b0; wr_req_valid = 1'b0; wr_req_addr = '0;
    wr_req_data = '0; wr_req_mdata = '0;
    #2;
    tests_run++;
    if (rd_rsp_valid !== 1'b0 || wr_rsp_valid !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valids: got rd=%b wr=%b ovf=%b want 0 0 0", rd_rsp_valid, wr_rsp_valid, overflow);
    end
    tests_run++;
    if (rd_alm_full !== 1'b0 || idle !== 1'b1 || wr_alm_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got alm=%b idle=%b walm=%b want 0 1 0", rd_alm_full, idle, wr_alm_full);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    int start;
    logic [DW-1:0] exp;
    clear_rsp();
    for (int a = 0; a < 4; a++) begin
      wr_req_valid = 1'b1; wr_req_addr = AW'(a);
      wr_req_data = DW'(a * 17); wr_req_mdata = MW'(16'h0100 + a);
      step();
      tests_run++;
      if (wr_rsp_valid !== 1'b1 || wr_rsp_mdata !== MW'(16'h0100 + a)) begin
        tests_failed++;
        $display("FAIL wr_rsp[%0d]: got v=%b md=%h want 1 %h", a, wr_rsp_valid, wr_rsp_mdata, 16'h0100 + a);
      end
    end
    wr_req_valid = 1'b0;
    step();
    tests_run++;
    if (wr_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_rsp_drop: got %b want 0", wr_rsp_valid);
    end
    start = cyc;
    for (int a = 0; a < 4; a++) begin
      rd_req_valid = 1'b1; rd_req_addr = AW'(a); rd_req_mdata = MW'(16'h0200 + a);
      step();
    end
    rd_req_valid = 1'b0;
    wait_rsp(4, 40);
    tests_run++;
    if (data_q.size() !== 4) begin
      tests_failed++;
      $display("FAIL rd_count: got %0d want 4", data_q.size());
    end else begin
      for (int a = 0; a < 4; a++) begin
        exp = DW'(a * 17);
        tests_run++;
        if (data_q[a] !== exp || mdata_q[a] !== MW'(16'h0200 + a) || cyc_q[a] - start !== LAT + 2 + a) begin
          tests_failed++;
          $display("FAIL rd_rsp[%0d]: got data=%h md=%h lat=%0d want %h %h %0d",
                   a, data_q[a][31:0], mdata_q[a], cyc_q[a] - start, exp[31:0], 16'h0200 + a, LAT + 2 + a);
        end
      end
    end
    step();
    tests_run++;
    if (idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_rd_idle: got %b want 1", idle);
    end
  endtask

  task automatic test_alm_full();
    clear_rsp();
    rd_rsp_stall = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rd_req_valid = 1'b1; rd_req_addr = AW'(i); rd_req_mdata = MW'(16'h0300 + i);
      step();
      tests_run++;
      if (rd_alm_full !== ((i + 1) >= 56)) begin
        tests_failed++;
        $display("FAIL alm_full@%0d: got %b want %b", i + 1, rd_alm_full, (i + 1) >= 56);
      end
    end
    rd_req_valid = 1'b0;
    repeat (LAT + 2) step();
    tests_run++;
    if (overflow !== 1'b0 || data_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL alm_stalled: got ovf=%b rsp=%0d want 0 0", overflow, data_q.size());
    end
    rd_rsp_stall = 1'b0;
    wait_rsp(64, 200);
    repeat (3) step();
    tests_run++;
    if (data_q.size() !== 64) begin
      tests_failed++;
      $display("FAIL alm_count: got %0d want 64", data_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        tests_run++;
        if (mdata_q[i] !== MW'(16'h0300 + i) || cyc_q[i] !== cyc_q[0] + i) begin
          tests_failed++;
          $display("FAIL alm_order[%0d]: got md=%h dc=%0d want %h %0d",
                   i, mdata_q[i], cyc_q[i] - cyc_q[0], 16'h0300 + i, i);
        end
      end
    end
    tests_run++;
    if (idle !== 1'b1 || rd_alm_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL alm_idle: got idle=%b alm=%b want 1 0", idle, rd_alm_full);
    end
  endtask

  task automatic test_overflow();
    int seen65;
    clear_rsp();
    rd_rsp_stall = 1'b1;
    for (int i = 0; i < 65; i++) begin
      rd_req_valid = 1'b1; rd_req_addr = AW'(i); rd_req_mdata = MW'(16'h0400 + i);
      step();
    end
    rd_req_valid = 1'b0;
    repeat (LAT + 2) step();
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: got %b want 1", overflow);
    end
    rd_rsp_stall = 1'b0;
    wait_rsp(65, 200);
    repeat (20) step();
    seen65 = 0;
    foreach (mdata_q[i]) if (mdata_q[i] === MW'(16'h0440)) seen65 = 1;
    tests_run++;
    if (data_q.size() !== 64 || seen65 !== 0) begin
      tests_failed++;
      $display("FAIL ovf_rsp: got count=%0d seen65=%0d want 64 0", data_q.size(), seen65);
    end
    tests_run++;
    if (data_q.size() > 0 && mdata_q[data_q.size() - 1] !== MW'(16'h043F)) begin
      tests_failed++;
      $display("FAIL ovf_last: got %h want 043f", mdata_q[data_q.size() - 1]);
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_reset_inflight();
    clear_rsp();
    rd_rsp_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_req_valid = 1'b1; rd_req_addr = AW'(i); rd_req_mdata = MW'(16'h0700 + i);
      step();
    end
    rd_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (overflow !== 1'b0 || idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_async: got ovf=%b idle=%b want 0 1", overflow, idle);
    end
    step(); step();
    rst_n = 1'b1;
    rd_rsp_stall = 1'b0;
    repeat (30) step();
    tests_run++;
    if (data_q.size() !== 0 || overflow !== 1'b0 || idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_inflight: got rsp=%0d ovf=%b idle=%b want 0 0 1", data_q.size(), overflow, idle);
    end
  endtask

  task automatic test_collision();
    clear_rsp();
    wr_req_valid = 1'b1; wr_req_addr = AW'(5); wr_req_data = DW'(8'hAA); wr_req_mdata = MW'(16'h0055);
    step();
    wr_req_valid = 1'b0;
    rd_rsp_stall = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = AW'(5); rd_req_mdata = MW'(16'h0500);
    step();
    rd_req_valid = 1'b0;
    repeat (LAT) step();
    // Release the stall and write the same line in the pop cycle.
    rd_rsp_stall = 1'b0;
    wr_req_valid = 1'b1; wr_req_data = DW'(8'hBB);
    step();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_mdata = MW'(16'h0501);
    step();
    rd_req_valid = 1'b0;
    wait_rsp(2, 40);
    tests_run++;
    if (data_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL coll_count: got %0d want 2", data_q.size());
    end else begin
      tests_run++;
      if (data_q[0] !== DW'(8'hAA) || mdata_q[0] !== MW'(16'h0500)) begin
        tests_failed++;
        $display("FAIL coll_old: got %h md=%h want aa 0500", data_q[0][31:0], mdata_q[0]);
      end
      tests_run++;
      if (data_q[1] !== DW'(8'hBB) || mdata_q[1] !== MW'(16'h0501)) begin
        tests_failed++;
        $display("FAIL coll_new: got %h md=%h want bb 0501", data_q[1][31:0], mdata_q[1]);
      end
    end
  endtask

  task automatic test_alias_and_simultaneous();
    clear_rsp();
    wr_req_valid = 1'b1; wr_req_addr = AW'(12'h400); wr_req_data = DW'(32'hC0FFEE); wr_req_mdata = MW'(16'h0600);
    step();
    // Read and write on the same cycle: read line 2, write line 7.
    rd_req_valid = 1'b1; rd_req_addr = AW'(2); rd_req_mdata = MW'(16'h0602);
    wr_req_addr = AW'(7); wr_req_data = DW'(32'h7777); wr_req_mdata = MW'(16'h0607);
    step();
    tests_run++;
    if (wr_rsp_valid !== 1'b1 || wr_rsp_mdata !== MW'(16'h0607)) begin
      tests_failed++;
      $display("FAIL simul_wr: got v=%b md=%h want 1 0607", wr_rsp_valid, wr_rsp_mdata);
    end
    wr_req_valid = 1'b0;
    rd_req_addr = AW'(0); rd_req_mdata = MW'(16'h0601);
    step();
    rd_req_valid = 1'b0;
    wait_rsp(2, 40);
    tests_run++;
    if (data_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL alias_count: got %0d want 2", data_q.size());
    end else begin
      tests_run++;
      if (data_q[0] !== DW'(8'h22) || mdata_q[0] !== MW'(16'h0602)) begin
        tests_failed++;
        $display("FAIL simul_rd: got %h md=%h want 22 0602", data_q[0][31:0], mdata_q[0]);
      end
      tests_run++;
      if (data_q[1] !== DW'(32'hC0FFEE) || mdata_q[1] !== MW'(16'h0601)) begin
        tests_failed++;
        $display("FAIL alias: got %h md=%h want c0ffee 0601", data_q[1][31:0], mdata_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alm_full();
    test_overflow();
    test_reset_inflight();
    test_collision();
    test_alias_and_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cci_host_mem_responder.md
Name: cci_host_mem_responder

Overview:
- Host-side responder for the CCI-MPF read/write request channels: accepts c0Tx-style read requests and c1Tx-style write requests, and returns c0Rx-style read responses and c1Rx-style write responses from an on-chip cacheline memory.
- Stands in for FIU plus host memory, so DMA initiators can be exercised in synthesizable loopback or simulation.
- Provides programmable read latency, a response stall hook and almost-full backpressure.

Parameters:
- ADDR_WIDTH, 42, request cacheline address width.
- DATA_WIDTH, 512, cacheline width.
- MDATA_WIDTH, 16, metadata tag width, echoed in responses.
- MEM_ADDR_WIDTH, 10, log2 of the number of memory lines; index = addr[MEM_ADDR_WIDTH-1:0].
- RD_LATENCY, 8, cycles from read acceptance to read-response-queue entry; minimum 1.
- RSP_DEPTH, 64, read response queue depth; power of 2.
- ALM_FULL_SLACK, 8, headroom reserved for requests already committed by the initiator.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_req_valid  in  1  read request strobe; no ready signal.
- rd_req_addr  in  ADDR_WIDTH  read cacheline address.
- rd_req_mdata  in  MDATA_WIDTH  read tag.
- rd_alm_full  out  1  read backpressure.
- rd_rsp_stall  in  1  test hook; holds read responses while high.
- rd_rsp_valid  out  1  read response strobe.
- rd_rsp_data  out  DATA_WIDTH  read data.
- rd_rsp_mdata  out  MDATA_WIDTH  echoed read tag.
- wr_req_valid  in  1  write request strobe.
- wr_req_addr  in  ADDR_WIDTH  write cacheline address.
- wr_req_data  in  DATA_WIDTH  write data.
- wr_req_mdata  in  MDATA_WIDTH  write tag.
- wr_alm_full  out  1  write backpressure; constant 0.
- wr_rsp_valid  out  1  write response strobe.
- wr_rsp_mdata  out  MDATA_WIDTH  echoed write tag.
- overflow  out  1  sticky error flag.
- idle  out  1  no reads in flight and no write response pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_rsp_valid, wr_rsp_valid, overflow = 0.
  - rd_alm_full = 0; idle = 1.
  - Delay-line valids, queue pointers and counts cleared.
  - Memory contents are not reset.
  - Reset mid-operation discards all in-flight reads and pending write responses; no response is emitted after rst_n rises for any pre-reset request.
- Read pipeline:
  - An accepted request (addr index and mdata) enters a RD_LATENCY-stage delay line.
  - On exit from the delay line it is pushed into the response queue.
  - When the queue is non-empty and rd_rsp_stall = 0, the head is popped and the memory is read that cycle.
  - rd_rsp_valid, data and mdata are registered and appear the next cycle.
  - Unstalled total latency is RD_LATENCY+2 cycles from request to rd_rsp_valid.
  - Responses are strictly in request order, at most one per cycle.
- inflight = (valid entries in the delay line) + (queue count).
- rd_alm_full = 1 when inflight >= RSP_DEPTH - ALM_FULL_SLACK. It is combinational on registered state.
- Queue full boundary: if a delay-line exit arrives while the queue is full:
  - The entry is dropped.
  - overflow is set and stays set until reset.
  - A pop in the same cycle frees space first, so push plus pop at full does not drop.
- Writes:
  - Memory is written in the cycle wr_req_valid is sampled.
  - wr_rsp_valid and wr_rsp_mdata are asserted exactly 1 cycle later, one response per request, including back-to-back requests.
- Read/write collision: a read pop and a write to the same index in the same cycle returns the OLD data (read-first). A pop one or more cycles after the write sees the new data.
- Simultaneous rd_req_valid and wr_req_valid are both accepted; the channels are independent.
- Address bits above MEM_ADDR_WIDTH are ignored, so addresses alias modulo 2^MEM_ADDR_WIDTH.
- idle = (inflight == 0) && !wr_rsp_valid && !rd_rsp_valid.

Test Plan:
- Write addr 0..3 with data = addr*0x11, then read addr 0..3 -> wr_rsp_valid one cycle after each write; rd_rsp data 0x00, 0x11, 0x22, 0x33 with matching mdata, first response 10 cycles after the first read request (RD_LATENCY=8).
- Issue 64 back-to-back reads with rd_rsp_stall=1 -> rd_alm_full rises on the cycle inflight reaches 56 and overflow stays 0. Release the stall -> 64 in-order responses on consecutive cycles, then idle = 1.
- Issue 65 reads under stall while ignoring rd_alm_full -> overflow = 1 and sticky; 64 responses are emitted; the 65th mdata never appears.
- Write 0xAA to addr 5, then in the same cycle as the pop of a pending read to addr 5 write 0xBB -> that read returns 0xAA; a subsequent read returns 0xBB.
- Write to addr 0x400 with MEM_ADDR_WIDTH=10, then read addr 0 -> returns the 0x400 data (aliasing).
- Assert rst_n low with 10 reads in flight -> no rd_rsp_valid after release; overflow = 0; idle = 1.
